sub_rr_sched: RTL and testbench
===============================

// Module: sub_rr_sched
// PURPOSE
//  - Round-robin scheduler sharing one pipelined SUB transform unit among NREQ requesters.
//  - Accepts valid/ready requests and issues one per cycle to the unit, tagged with requester index.
//  - Routes tagged results back to the originating requester.
//  - Bounds in-flight work with a credit counter; FLUSH drains the unit and re-homes the pointer.
// PARAMETERS
//  NREQ    5   number of requesters (2..8)
//  WD      4   data width per request/result
//  TW      3   tag width; must satisfy 2**TW >= NREQ
//  MAXOUT  4   max outstanding issues to unit (1..15)
// PORTS
//  CLK         in   1        clock, rising edge
//  RST_X       in   1        asynchronous reset, active-low
//  REQ_VALID   in   NREQ     request valid, bit i = requester i
//  REQ_DATA    in   NREQ*WD  request data, [i*WD +: WD] = requester i
//  REQ_READY   out  NREQ     one-hot grant (combinational)
//  FLUSH       in   1        stop issuing, drain, reset pointer
//  UNIT_VALID  out  1        issue strobe to SUB unit (registered)
//  UNIT_DATA   out  WD       issued data
//  UNIT_TAG    out  TW       issued requester index
//  UNIT_RVALID in   1        result strobe from unit
//  UNIT_RDATA  in   WD       result data
//  UNIT_RTAG   in   TW       result tag
//  RSP_VALID   out  NREQ     one-cycle result pulse to requester (registered)
//  RSP_DATA    out  WD       result data, shared across requesters
//  BUSY        out  1        outstanding count != 0 or state != RUN
//  ERR         out  1        sticky protocol error
// BEHAVIOUR
//  - Reset (RST_X=0, async) values:
//    - REQ_READY=0, UNIT_VALID=0, UNIT_DATA=0, UNIT_TAG=0
//    - RSP_VALID=0, RSP_DATA=0, BUSY=0, ERR=0
//    - ptr=0, outstanding=0, state=RUN
//  - Reset mid-operation discards all in-flight tags. Results arriving after reset count as unexpected (see ERR).
//  - States:
//    - RUN: grant enabled.
//    - DRAIN: FLUSH seen; no grants.
//    - HOME: single cycle; ptr<=0, then RUN.
//  - Transitions:
//    - RUN->DRAIN when FLUSH=1.
//    - DRAIN->HOME when outstanding==0 and FLUSH=0.
//    - FLUSH held keeps DRAIN.
//  - Grant:
//    - Only in RUN, with FLUSH=0 and outstanding<MAXOUT.
//    - Grant the first i with REQ_VALID[i]=1, searching ptr, ptr+1, ... mod NREQ.
//    - At most one REQ_READY bit set. REQ_READY never depends on REQ_DATA.
//  - Transfer occurs when REQ_VALID[i]&REQ_READY[i]. Then:
//    - ptr <= (i+1) mod NREQ.
//    - Next cycle: UNIT_VALID=1, UNIT_TAG=i, UNIT_DATA=REQ_DATA[i]. Issue latency is 1 cycle.
//  - No transfer: UNIT_VALID=0 next cycle. UNIT_DATA/TAG hold their last values.
//  - Outstanding counter:
//    - +1 on transfer, -1 on accepted UNIT_RVALID.
//    - Both in the same cycle: unchanged.
//    - Saturating width ceil(log2(MAXOUT+1)).
//  - Result routing: UNIT_RVALID with RTAG<NREQ and outstanding>0 gives, next cycle:
//    - RSP_VALID[RTAG]=1, RSP_DATA=UNIT_RDATA.
//    - RSP_VALID drops the following cycle unless another result arrives.
//  - Bad results: UNIT_RVALID with RTAG>=NREQ or outstanding==0.
//    - Result is dropped, ERR<=1, counter unchanged.
//    - ERR clears only on reset.
//  - Full boundary: outstanding==MAXOUT forces REQ_READY=0. A same-cycle UNIT_RVALID does not re-enable the grant until the next cycle.
//  - No requests pending: ptr holds.
// CONFIGURATION
//  - SUB_RR_SCHED_INVERT_ODD_EN defined:
//    - Data from odd-indexed requesters is bitwise inverted on issue: UNIT_DATA=~REQ_DATA[i] for i odd.
//    - Even indices pass unchanged. Results are never inverted.
//  - Not defined: all data passes unchanged.
// TESTING
//  1. Reset, REQ_VALID=5'b11111 held, results looped back after 2 cycles:
//     -> grants in order 0,1,2,3,4,0; UNIT_TAG follows 1 cycle later; no ERR.
//  2. REQ_VALID=5'b10100 with ptr=3:
//     -> grant order 4,2,4,2; ptr skips idle requesters.
//  3. MAXOUT=4, unit never returns, all valid:
//     -> exactly 4 transfers, then REQ_READY=0.
//     -> one UNIT_RVALID (tag 0, data 4'hA): next cycle RSP_VALID=5'b00001, RSP_DATA=4'hA; one more grant the cycle after.
//  4. FLUSH=1 with 3 outstanding, results in 3 later cycles:
//     -> no grants; BUSY=1; after the 3rd result and FLUSH=0, one HOME cycle; first grant goes to requester 0.
//  5. UNIT_RVALID with RTAG=6, and separately with outstanding=0:
//     -> no RSP_VALID; ERR=1 sticky; RST_X pulse clears ERR and counters mid-traffic.
//  6. SUB_RR_SCHED_INVERT_ODD_EN defined, REQ_DATA[1]=4'h3, REQ_DATA[2]=4'h3:
//     -> issued UNIT_DATA 4'hC (tag 1) and 4'h3 (tag 2).

Source files
------------

// File: rtl/sub_rr_sched.sv
// sub_rr_sched
//   Round-robin scheduler that shares one pipelined SUB transform unit among
//   NREQ requesters. One request per cycle is granted (valid/ready), issued
//   to the unit one cycle later with its requester index as tag, and the
//   tagged result is routed back to that requester as a one-cycle pulse.
//   A credit counter bounds the number of issues in flight. FLUSH stops
//   granting, waits for the unit to drain, then re-homes the pointer to 0.
//
// Ports
//   CLK, RST_X               clock (rising edge), async active-low reset
//   REQ_VALID/REQ_DATA       per-requester request, data [i*WD +: WD]
//   REQ_READY                one-hot combinational grant
//   FLUSH                    stop issuing, drain, reset pointer
//   UNIT_VALID/DATA/TAG      registered issue to the unit
//   UNIT_RVALID/RDATA/RTAG   result from the unit
//   RSP_VALID/RSP_DATA       registered result pulse, shared data bus
//   BUSY                     work outstanding or not in RUN
//   ERR                      sticky protocol error (bad tag / no credit)
//
// Configuration macro
//   SUB_RR_SCHED_INVERT_ODD_EN : invert issued data of odd requesters.

module sub_rr_sched #(
  parameter int unsigned NREQ   = 5,
  parameter int unsigned WD     = 4,
  parameter int unsigned TW     = 3,
  parameter int unsigned MAXOUT = 4
) (
  input  logic               CLK,
  input  logic               RST_X,
  input  logic [NREQ-1:0]    REQ_VALID,
  input  logic [NREQ*WD-1:0] REQ_DATA,
  output logic [NREQ-1:0]    REQ_READY,
  input  logic               FLUSH,
  output logic               UNIT_VALID,
  output logic [WD-1:0]      UNIT_DATA,
  output logic [TW-1:0]      UNIT_TAG,
  input  logic               UNIT_RVALID,
  input  logic [WD-1:0]      UNIT_RDATA,
  input  logic [TW-1:0]      UNIT_RTAG,
  output logic [NREQ-1:0]    RSP_VALID,
  output logic [WD-1:0]      RSP_DATA,
  output logic               BUSY,
  output logic               ERR
);

  localparam int unsigned CW = $clog2(MAXOUT + 1);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_HOME
  } state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   out_q, out_d;
  logic            uvalid_q, uvalid_d;
  logic [WD-1:0]   udata_q, udata_d;
  logic [TW-1:0]   utag_q, utag_d;
  logic [NREQ-1:0] rspv_q, rspv_d;
  logic [WD-1:0]   rspd_q, rspd_d;
  logic            err_q, err_d;

  logic            grant_en;
  logic            gnt_found;
  logic [TW-1:0]   gnt_idx;
  logic [TW:0]     cand;
  logic [NREQ-1:0] gnt_oh;
  logic [WD-1:0]   gnt_data;
  logic            rv_ok;

  // Rotating priority search starting at ptr. Candidate index is kept one
  // bit wider so ptr+k can wrap by a single subtraction.
  always_comb begin
    grant_en  = RST_X && (state_q == ST_RUN) && !FLUSH && (out_q < CW'(MAXOUT));
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr_q} + (TW+1)'(k);
      if (cand >= (TW+1)'(NREQ)) cand = cand - (TW+1)'(NREQ);
      if (grant_en && !gnt_found && REQ_VALID[cand[TW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[TW-1:0];
      end
    end
    gnt_oh = '0;
    if (gnt_found) gnt_oh[gnt_idx] = 1'b1;
  end

  always_comb begin
    gnt_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt_idx == TW'(i)) gnt_data = REQ_DATA[i*WD +: WD];
    end
`ifdef SUB_RR_SCHED_INVERT_ODD_EN
    if (gnt_idx[0]) gnt_data = ~gnt_data;
`endif
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    out_d    = out_q;
    uvalid_d = gnt_found;
    udata_d  = udata_q;
    utag_d   = utag_q;
    rspv_d   = '0;
    rspd_d   = rspd_q;
    err_d    = err_q;

    // A result is only honoured if its tag names a real requester and a
    // credit is actually outstanding; anything else is dropped as an error.
    rv_ok = UNIT_RVALID && ({1'b0, UNIT_RTAG} < (TW+1)'(NREQ)) && (out_q != '0);

    if (gnt_found) begin
      ptr_d   = (gnt_idx == TW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
      udata_d = gnt_data;
      utag_d  = gnt_idx;
    end

    if (gnt_found && !rv_ok) begin
      if (out_q != CW'(MAXOUT)) out_d = out_q + 1'b1;
    end else if (!gnt_found && rv_ok) begin
      out_d = out_q - 1'b1;
    end

    if (rv_ok) begin
      rspv_d[UNIT_RTAG] = 1'b1;
      rspd_d            = UNIT_RDATA;
    end
    if (UNIT_RVALID && !rv_ok) err_d = 1'b1;

    case (state_q)
      ST_RUN:   if (FLUSH) state_d = ST_DRAIN;
      ST_DRAIN: if ((out_q == '0) && !FLUSH) state_d = ST_HOME;
      ST_HOME: begin
        ptr_d   = '0;
        state_d = ST_RUN;
      end
      default:  state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state_q  <= ST_RUN;
      ptr_q    <= '0;
      out_q    <= '0;
      uvalid_q <= 1'b0;
      udata_q  <= '0;
      utag_q   <= '0;
      rspv_q   <= '0;
      rspd_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      out_q    <= out_d;
      uvalid_q <= uvalid_d;
      udata_q  <= udata_d;
      utag_q   <= utag_d;
      rspv_q   <= rspv_d;
      rspd_q   <= rspd_d;
      err_q    <= err_d;
    end
  end

  assign REQ_READY  = gnt_oh;
  assign UNIT_VALID = uvalid_q;
  assign UNIT_DATA  = udata_q;
  assign UNIT_TAG   = utag_q;
  assign RSP_VALID  = rspv_q;
  assign RSP_DATA   = rspd_q;
  assign BUSY       = (out_q != '0) || (state_q != ST_RUN);
  assign ERR        = err_q;

endmodule

// File: tb/tb_sub_rr_sched.sv
`timescale 1ns/1ps
module tb_sub_rr_sched;
  localparam int NREQ   = 5;
  localparam int WD     = 4;
  localparam int TW     = 3;
  localparam int MAXOUT = 4;
  localparam int VW     = 2*NREQ + 1 + TW + 2*WD + 2;

  logic               CLK = 1'b0;
  logic               RST_X = 1'b1;
  logic [NREQ-1:0]    REQ_VALID = '0;
  logic [NREQ*WD-1:0] REQ_DATA = '0;
  logic [NREQ-1:0]    REQ_READY;
  logic               FLUSH = 1'b0;
  logic               UNIT_VALID;
  logic [WD-1:0]      UNIT_DATA;
  logic [TW-1:0]      UNIT_TAG;
  logic               UNIT_RVALID = 1'b0;
  logic [WD-1:0]      UNIT_RDATA = '0;
  logic [TW-1:0]      UNIT_RTAG = '0;
  logic [NREQ-1:0]    RSP_VALID;
  logic [WD-1:0]      RSP_DATA;
  logic               BUSY;
  logic               ERR;

  always #5 CLK = ~CLK;

  sub_rr_sched #(.NREQ(NREQ), .WD(WD), .TW(TW), .MAXOUT(MAXOUT)) dut (
    .CLK(CLK), .RST_X(RST_X), .REQ_VALID(REQ_VALID), .REQ_DATA(REQ_DATA),
    .REQ_READY(REQ_READY), .FLUSH(FLUSH), .UNIT_VALID(UNIT_VALID),
    .UNIT_DATA(UNIT_DATA), .UNIT_TAG(UNIT_TAG), .UNIT_RVALID(UNIT_RVALID),
    .UNIT_RDATA(UNIT_RDATA), .UNIT_RTAG(UNIT_RTAG), .RSP_VALID(RSP_VALID),
    .RSP_DATA(RSP_DATA), .BUSY(BUSY), .ERR(ERR)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Reference model: scheduler described by its rules (pointer, credits, mode)
  int              m_ptr, m_out;
  string           m_mode;
  bit              m_uv, m_err;
  logic [TW-1:0]   m_utag;
  logic [WD-1:0]   m_udata, m_rdata;
  logic [NREQ-1:0] m_rsp;

  // Behavioural SUB unit: returns each issue lb_dly cycles after it appears
  typedef struct { int due; logic [TW-1:0] tag; logic [WD-1:0] data; } lb_t;
  lb_t lb_q[$];
  bit  lb_en = 1'b0;
  int  lb_dly = 2;

  task automatic model_reset();
    m_ptr = 0; m_out = 0; m_mode = "RUN"; m_uv = 0; m_err = 0;
    m_utag = '0; m_udata = '0; m_rdata = '0; m_rsp = '0;
  endtask

  function automatic int m_grant();
    if (!RST_X || m_mode != "RUN" || FLUSH || m_out >= MAXOUT) return -1;
    for (int k = 0; k < NREQ; k++)
      if (REQ_VALID[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    return -1;
  endfunction

  task automatic model_advance();
    int g; bit ok; logic [WD-1:0] d; string nm;
    g  = m_grant();
    ok = UNIT_RVALID && (int'(UNIT_RTAG) < NREQ) && (m_out > 0);
    nm = m_mode;
    if (m_mode == "RUN" && FLUSH) nm = "DRAIN";
    else if (m_mode == "DRAIN" && m_out == 0 && !FLUSH) nm = "HOME";
    else if (m_mode == "HOME") begin nm = "RUN"; m_ptr = 0; end
    m_uv = (g >= 0);
    if (g >= 0) begin
      d = REQ_DATA[g*WD +: WD];
`ifdef SUB_RR_SCHED_INVERT_ODD_EN
      if (g % 2 == 1) d = ~d;
`endif
      m_utag = TW'(g); m_udata = d; m_ptr = (g + 1) % NREQ;
      if (lb_en) lb_q.push_back(lb_t'{due: cyc + 1 + lb_dly, tag: TW'(g), data: d});
    end
    m_out = m_out + ((g >= 0) ? 1 : 0) - (ok ? 1 : 0);
    m_rsp = '0;
    if (ok) begin m_rsp[UNIT_RTAG] = 1'b1; m_rdata = UNIT_RDATA; end
    if (UNIT_RVALID && !ok) m_err = 1'b1;
    m_mode = nm;
    cyc++;
  endtask

  task automatic drive_lb();
    UNIT_RVALID = 1'b0;
    while (lb_q.size() > 0 && lb_q[0].due < cyc) lb_q.delete(0);
    if (lb_en && lb_q.size() > 0 && lb_q[0].due == cyc) begin
      UNIT_RVALID = 1'b1; UNIT_RTAG = lb_q[0].tag; UNIT_RDATA = lb_q[0].data;
      lb_q.delete(0);
    end
  endtask

  function automatic logic [VW-1:0] dut_vec();
    return {REQ_READY, UNIT_VALID, UNIT_TAG, UNIT_DATA, RSP_VALID, RSP_DATA, BUSY, ERR};
  endfunction

  function automatic logic [VW-1:0] model_vec();
    logic [NREQ-1:0] gm; int g; logic busy;
    g = m_grant(); gm = '0;
    if (g >= 0) gm[g] = 1'b1;
    busy = (m_out != 0) || (m_mode != "RUN");
    return {gm, m_uv, m_utag, m_udata, m_rsp, m_rdata, busy, m_err};
  endfunction

  function automatic int oh2idx(logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic do_reset();
    RST_X = 1'b0; UNIT_RVALID = 1'b0; #1;
    model_reset();
    @(negedge CLK); cyc++;
    RST_X = 1'b1;
  endtask

  task automatic test_reset();
    #2 RST_X = 1'b0;
    REQ_VALID = '1;
    model_reset();
    @(negedge CLK); #1;
    vectors++;
    if (dut_vec() !== model_vec()) begin
      miscompares++; $display("FAIL reset_state: got %h exp %h", dut_vec(), model_vec());
    end
    vectors++;
    if (REQ_READY !== '0) begin
      miscompares++; $display("FAIL reset_ready: got %b exp 0", REQ_READY);
    end
    @(negedge CLK); cyc++;
    REQ_VALID = '0; RST_X = 1'b1; #1;
    vectors++;
    if (dut_vec() !== model_vec()) begin
      miscompares++; $display("FAIL reset_idle: got %h exp %h", dut_vec(), model_vec());
    end
    model_advance(); @(negedge CLK);
  endtask

  task automatic test_round_robin();
    int got[6];
    int exp_o[6] = '{0, 1, 2, 3, 4, 0};
    lb_en = 1'b1; lb_dly = 2;
    for (int c = 0; c < 13; c++) begin
      if (c < 6) REQ_VALID = '1; else REQ_VALID = '0;
      REQ_DATA = (NREQ*WD)'($urandom);
      drive_lb(); #1;
      vectors++;
      if (dut_vec() !== model_vec()) begin
        miscompares++; $display("FAIL rr_cycle%0d: got %h exp %h", c, dut_vec(), model_vec());
      end
      if (c < 6) got[c] = oh2idx(REQ_READY);
      if (c >= 1 && c <= 6) begin
        vectors++;
        if (UNIT_VALID !== 1'b1 || int'(UNIT_TAG) != exp_o[c-1]) begin
          miscompares++; $display("FAIL rr_issue%0d: got v=%b tag=%0d exp v=1 tag=%0d", c, UNIT_VALID, UNIT_TAG, exp_o[c-1]);
        end
      end
      model_advance(); @(negedge CLK);
    end
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (got[i] != exp_o[i]) begin
        miscompares++; $display("FAIL rr_order%0d: got %0d exp %0d", i, got[i], exp_o[i]);
      end
    end
  endtask

  task automatic test_skip_idle();
    int got[4];
    int exp_o[4] = '{4, 2, 4, 2};
    lb_en = 1'b1; lb_dly = 2;
    for (int c = 0; c < 11; c++) begin
      if (c == 0) REQ_VALID = 5'b00100;
      else if (c <= 4) REQ_VALID = 5'b10100;
      else REQ_VALID = '0;
      REQ_DATA = (NREQ*WD)'($urandom);
      drive_lb(); #1;
      vectors++;
      if (dut_vec() !== model_vec()) begin
        miscompares++; $display("FAIL skip_cycle%0d: got %h exp %h", c, dut_vec(), model_vec());
      end
      if (c >= 1 && c <= 4) got[c-1] = oh2idx(REQ_READY);
      model_advance(); @(negedge CLK);
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (got[i] != exp_o[i]) begin
        miscompares++; $display("FAIL skip_order%0d: got %0d exp %0d", i, got[i], exp_o[i]);
      end
    end
  endtask

  task automatic test_full();
    int grants = 0;
    lb_en = 1'b0;
    for (int c = 0; c < 10; c++) begin
      REQ_VALID = '1;
      REQ_DATA = (NREQ*WD)'($urandom);
      UNIT_RVALID = (c == 7); UNIT_RTAG = '0; UNIT_RDATA = 4'hA;
      #1;
      vectors++;
      if (dut_vec() !== model_vec()) begin
        miscompares++; $display("FAIL full_cycle%0d: got %h exp %h", c, dut_vec(), model_vec());
      end
      if (c <= 6 && REQ_READY != '0) grants++;
      if (c == 6 || c == 7 || c == 9) begin
        vectors++;
        if (REQ_READY !== '0) begin
          miscompares++; $display("FAIL full_blocked%0d: got %b exp 0", c, REQ_READY);
        end
      end
      if (c == 8) begin
        vectors++;
        if (RSP_VALID !== 5'b00001 || RSP_DATA !== 4'hA || REQ_READY === '0) begin
          miscompares++; $display("FAIL full_release: got rsp=%b data=%h ready=%b exp rsp=00001 data=a ready!=0", RSP_VALID, RSP_DATA, REQ_READY);
        end
      end
      model_advance(); @(negedge CLK);
    end
    UNIT_RVALID = 1'b0;
    vectors++;
    if (grants != MAXOUT) begin
      miscompares++; $display("FAIL full_count: got %0d exp %0d", grants, MAXOUT);
    end
  endtask

  task automatic test_flush();
    int first_j = -1, first_idx = -1;
    lb_en = 1'b0;
    REQ_VALID = '0;
    do_reset();
    for (int j = 0; j <= 20 && first_j < 0; j++) begin
      REQ_VALID = '1;
      REQ_DATA = (NREQ*WD)'($urandom);
      FLUSH = (j >= 3 && j <= 9);
      UNIT_RVALID = (j == 5 || j == 7 || j == 9);
      UNIT_RTAG = TW'((j - 5) / 2); UNIT_RDATA = WD'((j - 5) / 2 + 1);
      #1;
      vectors++;
      if (dut_vec() !== model_vec()) begin
        miscompares++; $display("FAIL flush_cycle%0d: got %h exp %h", j, dut_vec(), model_vec());
      end
      if (j >= 3 && j <= 11) begin
        vectors++;
        if (REQ_READY !== '0 || BUSY !== 1'b1) begin
          miscompares++; $display("FAIL flush_hold%0d: got ready=%b busy=%b exp ready=0 busy=1", j, REQ_READY, BUSY);
        end
      end
      if (j >= 10 && REQ_READY != '0) begin first_j = j; first_idx = oh2idx(REQ_READY); end
      model_advance(); @(negedge CLK);
    end
    UNIT_RVALID = 1'b0; FLUSH = 1'b0;
    vectors++;
    if (first_j != 12 || first_idx != 0) begin
      miscompares++; $display("FAIL flush_home: got cycle %0d idx %0d exp cycle 12 idx 0", first_j, first_idx);
    end
  endtask

  task automatic test_err();
    lb_en = 1'b0; lb_dly = 2;
    for (int j = 0; j < 20; j++) begin
      if (j == 0 || j == 3 || j == 14) begin
        RST_X = 1'b0; UNIT_RVALID = 1'b0; #1;
        model_reset();
        vectors++;
        if (dut_vec() !== model_vec() || ERR !== 1'b0 || BUSY !== 1'b0) begin
          miscompares++; $display("FAIL err_reset%0d: got %h exp %h", j, dut_vec(), model_vec());
        end
        @(negedge CLK); cyc++;
        RST_X = 1'b1;
      end
      REQ_DATA = (NREQ*WD)'($urandom);
      REQ_VALID = '0; UNIT_RVALID = 1'b0; UNIT_RTAG = '0; UNIT_RDATA = '0;
      case (j)
        0: begin UNIT_RVALID = 1'b1; UNIT_RTAG = 3'd2; end
        3: REQ_VALID = 5'b00001;
        4: begin UNIT_RVALID = 1'b1; UNIT_RTAG = 3'd6; end
        5: begin UNIT_RVALID = 1'b1; UNIT_RTAG = 3'd0; UNIT_RDATA = 4'h5; end
        default: ;
      endcase
      if (j >= 7 && j <= 13) begin
        lb_en = 1'b1;
        REQ_VALID = (j >= 12) ? '1 : NREQ'($urandom);
      end
      if (lb_en) drive_lb();
      #1;
      vectors++;
      if (dut_vec() !== model_vec()) begin
        miscompares++; $display("FAIL err_cycle%0d: got %h exp %h", j, dut_vec(), model_vec());
      end
      if (j == 1 || j == 2 || j == 5) begin
        vectors++;
        if (ERR !== 1'b1 || RSP_VALID !== '0) begin
          miscompares++; $display("FAIL err_bad%0d: got err=%b rsp=%b exp err=1 rsp=0", j, ERR, RSP_VALID);
        end
      end
      if (j == 5) begin
        vectors++;
        if (BUSY !== 1'b1) begin
          miscompares++; $display("FAIL err_credit: got busy=%b exp 1", BUSY);
        end
      end
      if (j == 6) begin
        vectors++;
        if (RSP_VALID !== 5'b00001 || RSP_DATA !== 4'h5 || ERR !== 1'b1) begin
          miscompares++; $display("FAIL err_sticky: got rsp=%b data=%h err=%b exp 00001 5 1", RSP_VALID, RSP_DATA, ERR);
        end
      end
      if (j == 18) begin
        vectors++;
        if (ERR !== 1'b1 || RSP_VALID !== '0) begin
          miscompares++; $display("FAIL err_stale: got err=%b rsp=%b exp err=1 rsp=0", ERR, RSP_VALID);
        end
      end
      model_advance(); @(negedge CLK);
    end
    lb_en = 1'b0; UNIT_RVALID = 1'b0;
  endtask

  task automatic test_invert();
    bit seen1 = 0, seen2 = 0;
    logic [WD-1:0] exp1;
`ifdef SUB_RR_SCHED_INVERT_ODD_EN
    exp1 = 4'hC;
`else
    exp1 = 4'h3;
`endif
    lb_en = 1'b0;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      REQ_DATA = (NREQ*WD)'($urandom);
      REQ_DATA[1*WD +: WD] = 4'h3;
      REQ_DATA[2*WD +: WD] = 4'h3;
      REQ_VALID = (c < 2) ? 5'b00110 : 5'b00000;
      #1;
      vectors++;
      if (dut_vec() !== model_vec()) begin
        miscompares++; $display("FAIL inv_cycle%0d: got %h exp %h", c, dut_vec(), model_vec());
      end
      if (UNIT_VALID === 1'b1 && UNIT_TAG == 3'd1) begin
        seen1 = 1; vectors++;
        if (UNIT_DATA !== exp1) begin
          miscompares++; $display("FAIL inv_tag1: got %h exp %h", UNIT_DATA, exp1);
        end
      end
      if (UNIT_VALID === 1'b1 && UNIT_TAG == 3'd2) begin
        seen2 = 1; vectors++;
        if (UNIT_DATA !== 4'h3) begin
          miscompares++; $display("FAIL inv_tag2: got %h exp 3", UNIT_DATA);
        end
      end
      model_advance(); @(negedge CLK);
    end
    vectors++;
    if (!(seen1 && seen2)) begin
      miscompares++; $display("FAIL inv_seen: got tag1=%0d tag2=%0d exp both 1", seen1, seen2);
    end
  endtask

  task automatic test_random();
    int flush_left = 0;
    REQ_VALID = '0;
    do_reset();
    lb_en = 1'b1; lb_dly = 5;
    for (int c = 0; c < 300; c++) begin
      REQ_VALID = NREQ'($urandom);
      REQ_DATA = (NREQ*WD)'($urandom);
      if (flush_left > 0) begin FLUSH = 1'b1; flush_left--; end
      else begin
        FLUSH = 1'b0;
        if ($urandom_range(0, 40) == 0) flush_left = $urandom_range(1, 6);
      end
      drive_lb();
      if (!UNIT_RVALID && c > 200 && $urandom_range(0, 63) == 0) begin
        UNIT_RVALID = 1'b1; UNIT_RTAG = TW'($urandom_range(NREQ, 7));
      end
      #1;
      vectors++;
      if (dut_vec() !== model_vec()) begin
        miscompares++; $display("FAIL rand_cycle%0d: got %h exp %h", c, dut_vec(), model_vec());
      end
      model_advance(); @(negedge CLK);
    end
    FLUSH = 1'b0; UNIT_RVALID = 1'b0; lb_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    model_reset();
    test_reset();
    test_round_robin();
    test_skip_idle();
    test_full();
    test_flush();
    test_err();
    test_invert();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
